// File: rtl/serializer_lanes.sv
// Multi-lane serializer: a parallel word of L bits leaves LANES bits per beat, MSB- or LSB-first.
// An active slot plus one hold slot lets consecutive transactions stream with no idle cycles.
module serializer_lanes #(
   parameter int DATA_BUS_WIDTH = 16,
   parameter int DATA_MOD_WIDTH = $clog2(DATA_BUS_WIDTH),
   parameter int LANES          = 1,
   parameter int MIN_LEN        = 3
) (
   input  logic                      clk_i,
   input  logic                      arst_n_i,
   input  logic [DATA_BUS_WIDTH-1:0] data_i,
   input  logic [DATA_MOD_WIDTH-1:0] data_mod_i,
   input  logic                      msb_first_i,
   input  logic                      data_val_i,
   output logic                      data_rdy_o,
   output logic [LANES-1:0]          ser_data_o,
   output logic [LANES-1:0]          ser_data_mask_o,
   output logic                      ser_data_val_o,
   output logic                      ser_last_o,
   input  logic                      ser_rdy_i,
   output logic                      busy_o,
   output logic                      drop_o
);

   localparam int W        = DATA_BUS_WIDTH;
   localparam int LW       = $clog2(W) + 1;
   localparam int CW       = $clog2(W / LANES) + 1;
   localparam int LG_LANES = $clog2(LANES);

   typedef enum logic {IDLE, WORK} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    act_data_q, hld_data_q;
   logic [LW-1:0]   act_len_q, hld_len_q;
   logic [CW-1:0]   act_beats_q, hld_beats_q;
   logic            act_msb_q, hld_msb_q;
   logic [CW-1:0]   act_cnt_q;
   logic            hld_val_q, hld_val_d;
   logic            rdy_q, drop_q;

   logic [LW-1:0]   in_len;
   logic [LW:0]     in_sum;
   logic [CW-1:0]   in_beats;
   logic            accept, drop_w, store;
   logic            act_val, at_last, beat_xfer, last_xfer;
   logic            load_act_in, load_act_hold, load_hold;

   // Valid/ready: a word moves on data_val_i && data_rdy_o, a beat moves on ser_data_val_o && ser_rdy_i,
   // both at the rising edge; the offering side keeps its payload stable until the transfer happens.
   always_comb begin
      in_len   = (data_mod_i == '0) ? LW'(W) : LW'(data_mod_i);
      in_sum   = {1'b0, in_len} + (LW+1)'(LANES - 1);
      in_beats = CW'(in_sum >> LG_LANES);
   end

   assign accept    = data_val_i && rdy_q;
   assign drop_w    = accept && (data_mod_i != '0) && (int'(data_mod_i) < MIN_LEN);
   assign store     = accept && !drop_w;
   assign act_val   = (state_q == WORK);
   assign at_last   = (act_cnt_q == act_beats_q - CW'(1));
   assign beat_xfer = act_val && ser_rdy_i;
   assign last_xfer = beat_xfer && at_last;

   // rdy_q mirrors an empty hold slot, so an accepted word never lands on a full hold slot.
   assign load_act_in   = store && (!act_val || (last_xfer && !hld_val_q));
   assign load_act_hold = last_xfer && hld_val_q;
   assign load_hold     = store && act_val && !(last_xfer && !hld_val_q);

   always_comb begin
      hld_val_d = hld_val_q;
      if (load_act_hold)  hld_val_d = load_hold;
      else if (load_hold) hld_val_d = 1'b1;
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) state_q <= IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (store) state_d = WORK;
         WORK:    if (last_xfer && !hld_val_q && !store) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         act_data_q  <= '0;
         act_len_q   <= '0;
         act_beats_q <= '0;
         act_msb_q   <= 1'b0;
         act_cnt_q   <= '0;
         hld_data_q  <= '0;
         hld_len_q   <= '0;
         hld_beats_q <= '0;
         hld_msb_q   <= 1'b0;
         hld_val_q   <= 1'b0;
         rdy_q       <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         drop_q    <= drop_w;
         hld_val_q <= hld_val_d;
         rdy_q     <= !hld_val_d;
         if (load_act_in) begin
            act_data_q  <= data_i;
            act_len_q   <= in_len;
            act_beats_q <= in_beats;
            act_msb_q   <= msb_first_i;
            act_cnt_q   <= '0;
         end else if (load_act_hold) begin
            act_data_q  <= hld_data_q;
            act_len_q   <= hld_len_q;
            act_beats_q <= hld_beats_q;
            act_msb_q   <= hld_msb_q;
            act_cnt_q   <= '0;
         end else if (beat_xfer) begin
            act_cnt_q <= act_cnt_q + CW'(1);
         end
         if (load_hold) begin
            hld_data_q  <= data_i;
            hld_len_q   <= in_len;
            hld_beats_q <= in_beats;
            hld_msb_q   <= msb_first_i;
         end
      end
   end

   // Output decode: bit-reverse for MSB-first so both orders become a plain right shift.
   logic [W-1:0]     ord, shifted;
   logic [LW-1:0]    shamt, remain;
   logic [LANES-1:0] lane_mask;

   always_comb begin
      for (int i = 0; i < W; i++) ord[i] = act_msb_q ? act_data_q[W-1-i] : act_data_q[i];
      shamt   = LW'(act_cnt_q) << LG_LANES;
      shifted = ord >> shamt;
      remain  = act_len_q - shamt;
      for (int j = 0; j < LANES; j++) lane_mask[j] = act_val && (LW'(j) < remain);
      ser_data_o      = shifted[LANES-1:0] & lane_mask;
      ser_data_mask_o = lane_mask;
      ser_data_val_o  = act_val;
      ser_last_o      = act_val && at_last;
      busy_o          = act_val || hld_val_q;
      data_rdy_o      = rdy_q;
      drop_o          = drop_q;
   end

endmodule

// File: tb/tb_serializer_lanes.sv
// Bench for serializer_lanes: three instances (LANES = 1, 4, 16, W = 16) driven by directed steps,
// with a bit-level reference model filling per-instance expected-beat queues.
module tb_serializer_lanes;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        dv[3];
   logic [15:0] din[3];
   logic [3:0]  dmod[3];
   logic        dmsb[3];
   logic        srdy[3];
   logic        rdy[3], val[3], last[3], busy[3], drop[3];
   logic [0:0]  sd1, sm1;
   logic [3:0]  sd4, sm4;
   logic [15:0] sd16, sm16;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int beats[3];
   int rdy_fall1 = 0;
   logic prev_rdy1 = 1'b0;
   logic rand_done = 1'b0;

   // Expected beat layout: {last, mask[15:0], data[15:0]}, unused lanes zero.
   logic [32:0] exp_q0[$];
   logic [32:0] exp_q1[$];
   logic [32:0] exp_q2[$];
   int          cyc_q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   serializer_lanes #(.DATA_BUS_WIDTH(16), .LANES(1)) u_l1 (
      .clk_i(clk), .arst_n_i(arst_n), .data_i(din[0]), .data_mod_i(dmod[0]),
      .msb_first_i(dmsb[0]), .data_val_i(dv[0]), .data_rdy_o(rdy[0]),
      .ser_data_o(sd1), .ser_data_mask_o(sm1), .ser_data_val_o(val[0]),
      .ser_last_o(last[0]), .ser_rdy_i(srdy[0]), .busy_o(busy[0]), .drop_o(drop[0]));

   serializer_lanes #(.DATA_BUS_WIDTH(16), .LANES(4)) u_l4 (
      .clk_i(clk), .arst_n_i(arst_n), .data_i(din[1]), .data_mod_i(dmod[1]),
      .msb_first_i(dmsb[1]), .data_val_i(dv[1]), .data_rdy_o(rdy[1]),
      .ser_data_o(sd4), .ser_data_mask_o(sm4), .ser_data_val_o(val[1]),
      .ser_last_o(last[1]), .ser_rdy_i(srdy[1]), .busy_o(busy[1]), .drop_o(drop[1]));

   serializer_lanes #(.DATA_BUS_WIDTH(16), .LANES(16)) u_l16 (
      .clk_i(clk), .arst_n_i(arst_n), .data_i(din[2]), .data_mod_i(dmod[2]),
      .msb_first_i(dmsb[2]), .data_val_i(dv[2]), .data_rdy_o(rdy[2]),
      .ser_data_o(sd16), .ser_data_mask_o(sm16), .ser_data_val_o(val[2]),
      .ser_last_o(last[2]), .ser_rdy_i(srdy[2]), .busy_o(busy[2]), .drop_o(drop[2]));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int lanes_of(input int s);
      return (s == 0) ? 1 : (s == 1) ? 4 : 16;
   endfunction

   function automatic int qsize(input int s);
      case (s)
         0:       return exp_q0.size();
         1:       return exp_q1.size();
         default: return exp_q2.size();
      endcase
   endfunction

   function automatic logic [32:0] cur_beat(input int s);
      if (s == 0)      return {last[0], 15'b0, sm1, 15'b0, sd1};
      else if (s == 1) return {last[1], 12'b0, sm4, 12'b0, sd4};
      else             return {last[2], sm16, sd16};
   endfunction

   function automatic logic [32:0] front(input int s);
      case (s)
         0:       return exp_q0[0];
         1:       return exp_q1[0];
         default: return exp_q2[0];
      endcase
   endfunction

   // Reference model: beat k lane j carries bit position k*lanes+j of the chosen order, if below L.
   function automatic logic [32:0] model_beat(input int lanes, input logic [15:0] d, input int len,
                                              input logic msb, input int k, input int nb);
      logic [15:0] dd, mm, tmp;
      dd = '0;
      mm = '0;
      for (int j = 0; j < lanes; j++) begin
         int pos;
         pos = k * lanes + j;
         if (pos < len) begin
            tmp = d >> (msb ? (15 - pos) : pos);
            mm  = mm | (16'(1) << j);
            dd  = dd | (16'(tmp[0]) << j);
         end
      end
      return {(k == nb - 1), mm, dd};
   endfunction

   task automatic push_txn(input int s, input logic [15:0] d, input logic [3:0] mod, input logic msb);
      int lanes, len, nb;
      lanes = lanes_of(s);
      len   = (mod == 0) ? 16 : int'(mod);
      nb    = (len + lanes - 1) / lanes;
      for (int k = 0; k < nb; k++) begin
         case (s)
            0:       exp_q0.push_back(model_beat(lanes, d, len, msb, k, nb));
            1:       exp_q1.push_back(model_beat(lanes, d, len, msb, k, nb));
            default: exp_q2.push_back(model_beat(lanes, d, len, msb, k, nb));
         endcase
      end
   endtask

   task automatic mon_beat(input int s);
      logic [32:0] got, exp;
      chk("beat_expected", qsize(s) != 0, 1);
      if (qsize(s) != 0) begin
         got = cur_beat(s);
         case (s)
            0:       exp = exp_q0.pop_front();
            1:       exp = exp_q1.pop_front();
            default: exp = exp_q2.pop_front();
         endcase
         chk($sformatf("beat_l%0d", lanes_of(s)), got, exp);
      end
      beats[s]++;
      if (s == 1) cyc_q1.push_back(cyc);
   endtask

   always @(negedge clk) begin
      for (int s = 0; s < 3; s++) if (val[s] && srdy[s]) mon_beat(s);
      if (prev_rdy1 && !rdy[1]) rdy_fall1++;
      prev_rdy1 = rdy[1];
   end

   // Offer one word; waits (bounded) for data_rdy_o, then checks the drop pulse of the next cycle.
   task automatic send(input int s, input logic [15:0] d, input logic [3:0] mod, input logic msb);
      int  n;
      logic dropx;
      dropx   = (mod != 0) && (mod < 3);
      din[s]  = d;
      dmod[s] = mod;
      dmsb[s] = msb;
      dv[s]   = 1'b1;
      n = 0;
      @(negedge clk);
      while (!rdy[s] && n < 300) begin
         n++;
         @(negedge clk);
      end
      chk("accept_wait", n < 300, 1);
      if (!dropx) push_txn(s, d, mod, msb);
      @(posedge clk);
      #1;
      dv[s] = 1'b0;
      chk("drop_pulse", drop[s], dropx);
   endtask

   task automatic wait_idle(input int s);
      int n;
      n = 0;
      while ((qsize(s) != 0 || busy[s]) && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("idle_wait", n < 500, 1);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk(tag, {rdy[0], val[0], last[0], busy[0], drop[0], sm1, sd1}, 0);
      chk(tag, {rdy[1], val[1], last[1], busy[1], drop[1], sm4, sd4}, 0);
      chk(tag, {rdy[2], val[2], last[2], busy[2], drop[2], sm16, sd16}, 0);
   endtask

   initial begin
      int n;
      arst_n = 1'b0;
      for (int s = 0; s < 3; s++) begin
         dv[s] = 1'b0; din[s] = '0; dmod[s] = '0; dmsb[s] = 1'b0; srdy[s] = 1'b1; beats[s] = 0;
      end
      #3;
      chk_zero_outputs("reset_values");
      #9;
      arst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rdy_after_reset", {rdy[0], rdy[1], rdy[2]}, 3'b111);

      // LANES=1, full word, MSB-first; busy drops after the last beat.
      send(0, 16'hA5C3, 4'd0, 1'b1);
      n = 0;
      while (exp_q0.size() != 0 && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("a5c3_drain", n < 100, 1);
      chk("busy_last_beat", busy[0], 1);
      @(posedge clk);
      #1;
      chk("busy_after_last", {busy[0], val[0]}, 2'b00);

      // LANES=4 partial final beat, both orders.
      send(1, 16'h003D, 4'd6, 1'b0);
      wait_idle(1);
      send(1, 16'hBEEF, 4'd7, 1'b1);
      wait_idle(1);

      // Three full words back-to-back: 12 beats in 12 consecutive cycles.
      rdy_fall1 = 0;
      cyc_q1.delete();
      send(1, 16'h1357, 4'd0, 1'b1);
      send(1, 16'h2468, 4'd0, 1'b0);
      send(1, 16'h9ABC, 4'd0, 1'b1);
      wait_idle(1);
      chk("b2b_beats", cyc_q1.size(), 12);
      if (cyc_q1.size() >= 12) chk("b2b_no_gap", cyc_q1[11] - cyc_q1[0], 11);
      chk("b2b_rdy_fell", rdy_fall1 >= 1, 1);
      chk("b2b_rdy_back", rdy[1], 1);

      // Short word is dropped; a MIN_LEN word still serialises.
      send(0, 16'h1234, 4'd2, 1'b1);
      chk("drop_no_valid", {val[0], busy[0]}, 2'b00);
      @(posedge clk);
      #1;
      chk("drop_one_cycle", drop[0], 0);
      send(0, 16'hF00D, 4'd3, 1'b0);
      wait_idle(0);

      // Drop arriving while a transfer is in progress leaves it untouched.
      send(1, 16'hCAFE, 4'd0, 1'b1);
      send(1, 16'h5555, 4'd1, 1'b0);
      chk("drop_while_work_busy", busy[1], 1);
      wait_idle(1);

      // Stall mid-transaction: the presented beat stays put for 5 cycles.
      send(0, 16'h6C39, 4'd0, 1'b0);
      n = 0;
      while (beats[0] < 23 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      srdy[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_valid", val[0], 1);
         if (exp_q0.size() != 0) chk("stall_hold", cur_beat(0), front(0));
      end
      @(posedge clk);
      #1;
      srdy[0] = 1'b1;
      wait_idle(0);

      // LANES=W: single beat with full mask, then a partial single beat.
      send(2, 16'h9A5C, 4'd0, 1'b1);
      send(2, 16'h00F3, 4'd5, 1'b0);
      wait_idle(2);

      // Random words with random downstream backpressure on the LANES=4 instance.
      rand_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 12; i++)
               send(1, 16'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1;
               srdy[1] = 1'($urandom_range(0, 1));
            end
            srdy[1] = 1'b1;
         end
      join
      wait_idle(1);

      // Reset while beat 7 of 16 is presented.
      n = beats[0];
      send(0, 16'hE71B, 4'd0, 1'b1);
      while (beats[0] < n + 7 && cyc < 90000) begin
         @(posedge clk);
         #1;
      end
      chk("reset_mid_beat7", beats[0] - n, 7);
      arst_n = 1'b0;
      exp_q0.delete();
      #1;
      chk_zero_outputs("reset_mid");
      #1;
      arst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rdy_after_mid_reset", {rdy[0], val[0]}, 2'b10);
      send(0, 16'h0F1E, 4'd0, 1'b1);
      wait_idle(0);

      chk("q0_empty", exp_q0.size(), 0);
      chk("q1_empty", exp_q1.size(), 0);
      chk("q2_empty", exp_q2.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish expected finish by 400000");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/serializer_lanes.md
# serializer_lanes

Parametrised multi-lane serializer with a valid/ready input, a two-entry transaction buffer and downstream backpressure. It accepts a parallel word and a bit count, then emits the selected bits LANES per beat, in a bit order chosen per transaction. The block replaces the single-lane busy-gated serializer on streaming paths that need back-to-back transactions without idle cycles.

## Interface
- DATA_BUS_WIDTH, default 16: parallel word width W; must be a multiple of LANES.
- DATA_MOD_WIDTH, default $clog2(DATA_BUS_WIDTH): width of data_mod_i.
- LANES, default 1: serial bits per beat; power of two, 1..W.
- MIN_LEN, default 3: a non-zero data_mod_i below MIN_LEN drops the transaction.

Ports:
- clk_i  in  1  clock; the block has one clock.
- arst_n_i  in  1  reset, asynchronous, active-low.
- data_i  in  W  parallel data.
- data_mod_i  in  DATA_MOD_WIDTH  bit count L; 0 means L = W.
- msb_first_i  in  1  1 = MSB-first, 0 = LSB-first; sampled with the data.
- data_val_i  in  1  input valid.
- data_rdy_o  out  1  input ready; registered.
- ser_data_o  out  LANES  serial beat; lane 0 goes first in bit order.
- ser_data_mask_o  out  LANES  lane-valid mask.
- ser_data_val_o  out  1  beat valid.
- ser_last_o  out  1  final beat of the transaction.
- ser_rdy_i  in  1  downstream ready.
- busy_o  out  1  any transaction is held.
- drop_o  out  1  one-cycle pulse for a dropped transaction.

## Operation
**Handshakes**
- Input accept: data_val_i && data_rdy_o at a rising edge.
- Beat transfer: ser_data_val_o && ser_rdy_i.

**Storage and state**
- Active slot: data, L, bit order, beat counter, valid flag.
  - State IDLE: the active slot is empty.
  - State WORK: the active slot is full.
- Hold slot: one further transaction plus its valid flag.
- data_rdy_o is registered: next value = !(hold valid after this edge).

**Transaction length**
- Dropped transaction: 0 < data_mod_i < MIN_LEN.
  - The handshake completes, but nothing is stored.
  - drop_o is 1 in the following cycle.
- Beat count B = ceil(L/LANES). Counter arithmetic is $clog2(W/LANES)+1 bits.
- Mapping for beat k (0-based), lane j:
  - MSB-first: data[W-1-(k*LANES+j)].
  - LSB-first: data[k*LANES+j].
- Lane j is valid when k*LANES+j < L.
  - Invalid lanes drive 0 and mask 0.
  - Only the final beat can be partial.

**Load rules**
- An accepted word goes to the active slot if either:
  - the active slot is empty, or
  - the active slot completes its last beat this cycle and the hold slot is empty.
- Otherwise it goes to the hold slot.
- When the last beat transfers and the hold slot is valid:
  - the hold slot moves to the active slot;
  - a simultaneously accepted word goes into the hold slot.

**Outputs**
- Outputs decode the active slot.
  - ser_data_val_o = active valid.
  - ser_last_o = active valid && (k == B-1).
- busy_o = active valid || hold valid.

## Timing
**Reset values** (all forced asynchronously while arst_n_i = 0; both slots invalidated, state = IDLE):
- data_rdy_o = 0; it rises at the first clock edge after release.
- ser_data_o = 0, ser_data_mask_o = 0.
- ser_data_val_o = 0, ser_last_o = 0.
- busy_o = 0, drop_o = 0.

**Latency and throughput**
- Latency: a word accepted at edge N presents beat 0 in the cycle after edge N.
- With ser_rdy_i held at 1, one beat per cycle.
- No bubble between consecutive transactions when the next word is already held or is accepted in the last-beat cycle.

**Stall and flow control**
- While ser_rdy_i = 0, all ser_* outputs hold stable.
- Input backpressure: data_rdy_o falls the cycle after the hold slot fills.
  - A word presented while data_rdy_o = 0 is not accepted and must be held by the source.

**Boundary conditions**
- L = W with LANES = W: single beat with full mask, ser_last_o = 1.
- Reset mid-transaction: the transaction is discarded with no partial completion; outputs return to reset values immediately.
- Drop while WORK: the active transfer is unaffected.

## Test plan
- W=16, LANES=1, mod=0, msb_first=1, data=16'hA5C3, ser_rdy_i=1: 16 beats 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; ser_last_o on beat 15; busy_o falls after it.
- W=16, LANES=4, mod=6, LSB-first, data=16'h003D: beat 0 = 4'hD with mask 4'hF; beat 1 = 4'h3 with mask 4'h3 and ser_last_o=1.
- Three words offered back-to-back with mod=0, LANES=4, ser_rdy_i=1: 12 consecutive valid beats with no gap; data_rdy_o drops once while the hold slot is full.
- mod=2 (MIN_LEN=3): handshake completes, drop_o pulses for 1 cycle, ser_data_val_o stays 0; with mod=3 the next word serialises 3 bits.
- ser_rdy_i held at 0 for 5 cycles mid-transaction: ser_data_o, ser_data_mask_o and ser_last_o are constant; the beat sequence resumes unchanged afterwards.
- arst_n_i pulsed low at beat 7 of 16: all outputs are 0 within that low phase; the first edge after release sets data_rdy_o=1 and a new word serialises from beat 0.
